data_mem_arbiter: RTL and testbench

- Shares the data-memory read port between two requesters: the CPU (port 0) and the GPU display-list fetcher (port 1).
- The write port is CPU-only and is passed straight through to memory.
- Read arbitration is round-robin, with bounded GPU bursts so the CPU is never starved.
- Sits between cpu/gpu and the data bsram; memory read latency is 1 cycle.

---
 rtl/data_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Round-robin CPU/GPU read arbiter for the data bsram with
//               bounded GPU bursts; the CPU write port passes straight through.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 13,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd_req,
    input  logic [DATA_WIDTH-1:0] cpu_rd_addr,
    output logic                  cpu_stall,
    output logic                  cpu_rd_valid,
    output logic [15:0]           cpu_rd_data,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wr_addr,
    input  logic [15:0]           cpu_wr_data,
    input  logic                  gpu_req,
    input  logic [DATA_WIDTH-1:0] gpu_addr,
    output logic                  gpu_grant,
    output logic                  gpu_rd_valid,
    output logic [15:0]           gpu_rd_data,
    output logic [DATA_WIDTH-1:0] mem_din_addr,
    input  logic [15:0]           mem_din,
    output logic                  mem_dout_we,
    output logic [DATA_WIDTH-1:0] mem_dout_addr,
    output logic [15:0]           mem_dout
);

    localparam int                 c_CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CPU  = 2'd1;
    localparam logic [1:0] c_GPU  = 2'd2;

    logic [1:0]         r_owner;
    logic [1:0]         w_owner_nxt;
    logic [c_CNT_W-1:0] r_burst_cnt;
    logic [c_CNT_W-1:0] w_burst_cnt_nxt;
    logic               r_last_gpu;
    logic               w_last_gpu_nxt;
    logic               r_cpu_rd_valid;
    logic               r_gpu_rd_valid;
    logic               w_grant_cpu;
    logic               w_grant_gpu;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner        <= c_IDLE;
            r_burst_cnt    <= '0;
            r_last_gpu     <= 1'b0;
            r_cpu_rd_valid <= 1'b0;
            r_gpu_rd_valid <= 1'b0;
        end else begin
            r_owner        <= w_owner_nxt;
            r_burst_cnt    <= w_burst_cnt_nxt;
            r_last_gpu     <= w_last_gpu_nxt;
            r_cpu_rd_valid <= w_grant_cpu;
            r_gpu_rd_valid <= w_grant_gpu;
        end
    end

    // Grant decision and next-state
    always_comb begin
        w_grant_cpu     = 1'b0;
        w_grant_gpu     = 1'b0;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        w_last_gpu_nxt  = r_last_gpu;

        if (cpu_rd_req && gpu_req) begin
            // A running GPU burst keeps the port until the cap; otherwise alternate.
            if (r_owner == c_GPU) begin
                w_grant_gpu = (r_burst_cnt < c_MAX);
            end else begin
                w_grant_gpu = !r_last_gpu;
            end
            w_grant_cpu = !w_grant_gpu;
        end else begin
            w_grant_gpu = gpu_req;
            w_grant_cpu = cpu_rd_req;
        end

        if (w_grant_cpu) begin
            w_owner_nxt     = c_CPU;
            w_burst_cnt_nxt = '0;
            w_last_gpu_nxt  = 1'b0;
        end else if (w_grant_gpu) begin
            w_owner_nxt     = c_GPU;
            w_last_gpu_nxt  = 1'b1;
            w_burst_cnt_nxt = (r_burst_cnt == c_MAX) ? r_burst_cnt : r_burst_cnt + c_ONE;
        end else begin
            w_owner_nxt     = c_IDLE;
            w_burst_cnt_nxt = '0;
        end
    end

    // Outputs
    always_comb begin
        gpu_grant     = w_grant_gpu;
        cpu_stall     = cpu_rd_req & ~w_grant_cpu;
        mem_din_addr  = w_grant_gpu ? gpu_addr : cpu_rd_addr;
        cpu_rd_valid  = r_cpu_rd_valid;
        gpu_rd_valid  = r_gpu_rd_valid;
        cpu_rd_data   = mem_din;
        gpu_rd_data   = mem_din;
        mem_dout_we   = cpu_we;
        mem_dout_addr = cpu_wr_addr;
        mem_dout      = cpu_wr_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Directed self-checking bench for data_mem_arbiter with a
//               1-cycle-latency bsram model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd_req;
    logic [12:0] cpu_rd_addr;
    logic        cpu_stall;
    logic        cpu_rd_valid;
    logic [15:0] cpu_rd_data;
    logic        cpu_we;
    logic [12:0] cpu_wr_addr;
    logic [15:0] cpu_wr_data;
    logic        gpu_req;
    logic [12:0] gpu_addr;
    logic        gpu_grant;
    logic        gpu_rd_valid;
    logic [15:0] gpu_rd_data;
    logic [12:0] mem_din_addr;
    logic [15:0] mem_din;
    logic        mem_dout_we;
    logic [12:0] mem_dout_addr;
    logic [15:0] mem_dout;

    logic [15:0] mem [0:8191];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DATA_WIDTH(13), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_stall(cpu_stall),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
        .cpu_we(cpu_we), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_grant(gpu_grant),
        .gpu_rd_valid(gpu_rd_valid), .gpu_rd_data(gpu_rd_data),
        .mem_din_addr(mem_din_addr), .mem_din(mem_din),
        .mem_dout_we(mem_dout_we), .mem_dout_addr(mem_dout_addr), .mem_dout(mem_dout)
    );

    // bsram: registered read (old data on collision), synchronous write
    always @(posedge clk) begin
        if (mem_dout_we) mem[mem_dout_addr] <= mem_dout;
        mem_din <= mem[mem_din_addr];
    end

    function automatic logic [15:0] pre(input int a);
        return 16'h1000 + a[15:0];
    endfunction

    task automatic apply_reset;
        @(negedge clk);
        cpu_rd_req = 1'b0; gpu_req = 1'b0; cpu_we = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        cpu_rd_req = 1'b1; cpu_rd_addr = 13'd5;
        gpu_req = 1'b1; gpu_addr = 13'd9;
        cpu_we = 1'b0; cpu_wr_addr = 13'd0; cpu_wr_data = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (cpu_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_cpu_valid got=%b exp=0", cpu_rd_valid); end
        total++; if (gpu_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_gpu_valid got=%b exp=0", gpu_rd_valid); end
        @(negedge clk);
        cpu_rd_req = 1'b0; gpu_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        cpu_rd_req = 1'b1; cpu_rd_addr = 13'd5;
        #1;
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL first_read_stall got=%b exp=0", cpu_stall); end
        total++; if (mem_din_addr !== 13'd5) begin bad++; $display("FAIL first_read_addr got=%0d exp=5", mem_din_addr); end
        @(posedge clk); #1;
        total++; if (cpu_rd_valid !== 1'b1) begin bad++; $display("FAIL first_read_valid got=%b exp=1", cpu_rd_valid); end
        total++; if (cpu_rd_data !== pre(5)) begin bad++; $display("FAIL first_read_data got=%h exp=%h", cpu_rd_data, pre(5)); end
        total++; if (gpu_rd_valid !== 1'b0) begin bad++; $display("FAIL first_read_gpu_valid got=%b exp=0", gpu_rd_valid); end
        @(negedge clk);
        cpu_rd_req = 1'b0;
    endtask

    task automatic test_cpu_stream;
        int nvalid = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cpu_rd_req = 1'b1; cpu_rd_addr = 13'(i);
            #1;
            total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL stream_stall[%0d] got=%b exp=0", i, cpu_stall); end
            @(posedge clk); #1;
            if (cpu_rd_valid === 1'b1) nvalid++;
            total++; if (cpu_rd_data !== pre(i)) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, cpu_rd_data, pre(i)); end
        end
        total++; if (nvalid != 16) begin bad++; $display("FAIL stream_valid_count got=%0d exp=16", nvalid); end
        @(negedge clk);
        cpu_rd_req = 1'b0;
    endtask

    task automatic test_contention;
        apply_reset;
        @(negedge clk);
        cpu_rd_req = 1'b1; cpu_rd_addr = 13'd7;
        gpu_req = 1'b1; gpu_addr = 13'd200;
        #1;
        total++; if (gpu_grant !== 1'b1) begin bad++; $display("FAIL contend_gpu_grant got=%b exp=1", gpu_grant); end
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL contend_cpu_stall got=%b exp=1", cpu_stall); end
        total++; if (mem_din_addr !== 13'd200) begin bad++; $display("FAIL contend_addr got=%0d exp=200", mem_din_addr); end
        @(posedge clk); #1;
        total++; if (gpu_rd_valid !== 1'b1 || gpu_rd_data !== pre(200)) begin bad++; $display("FAIL contend_gpu_data got=%b/%h exp=1/%h", gpu_rd_valid, gpu_rd_data, pre(200)); end
        total++; if (cpu_rd_valid !== 1'b0) begin bad++; $display("FAIL contend_cpu_valid got=%b exp=0", cpu_rd_valid); end
        @(negedge clk);
        gpu_req = 1'b0;
        #1;
        total++; if (cpu_stall !== 1'b0 || gpu_grant !== 1'b0) begin bad++; $display("FAIL contend_cpu_turn got=stall%b/grant%b exp=0/0", cpu_stall, gpu_grant); end
        total++; if (mem_din_addr !== 13'd7) begin bad++; $display("FAIL contend_cpu_addr got=%0d exp=7", mem_din_addr); end
        @(posedge clk); #1;
        total++; if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== pre(7)) begin bad++; $display("FAIL contend_cpu_data got=%b/%h exp=1/%h", cpu_rd_valid, cpu_rd_data, pre(7)); end
        @(negedge clk);
        cpu_rd_req = 1'b0;
    endtask

    task automatic test_burst_cap;
        int  run = 0;
        int  max_run = 0;
        logic exp_g;
        apply_reset;
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            cpu_rd_req = 1'b1; cpu_rd_addr = 13'd40;
            gpu_req = 1'b1; gpu_addr = 13'(300 + c);
            exp_g = ((c % 9) != 8);
            #1;
            total++; if (gpu_grant !== exp_g) begin bad++; $display("FAIL burst_grant[%0d] got=%b exp=%b", c, gpu_grant, exp_g); end
            total++; if (cpu_stall !== exp_g) begin bad++; $display("FAIL burst_stall[%0d] got=%b exp=%b", c, cpu_stall, exp_g); end
            if (cpu_stall === 1'b1) run++; else run = 0;
            if (run > max_run) max_run = run;
            @(posedge clk); #1;
            total++; if (gpu_rd_valid !== exp_g || cpu_rd_valid !== !exp_g) begin bad++; $display("FAIL burst_valid[%0d] got=g%b/c%b exp=g%b", c, gpu_rd_valid, cpu_rd_valid, exp_g); end
            if (exp_g) begin
                total++; if (gpu_rd_data !== pre(300 + c)) begin bad++; $display("FAIL burst_gdata[%0d] got=%h exp=%h", c, gpu_rd_data, pre(300 + c)); end
            end else begin
                total++; if (cpu_rd_data !== pre(40)) begin bad++; $display("FAIL burst_cdata[%0d] got=%h exp=%h", c, cpu_rd_data, pre(40)); end
            end
        end
        total++; if (max_run != 8) begin bad++; $display("FAIL burst_max_stall got=%0d exp=8", max_run); end
        @(negedge clk);
        cpu_rd_req = 1'b0; gpu_req = 1'b0;
    endtask

    task automatic test_write_during_burst;
        apply_reset;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            gpu_req = 1'b1; gpu_addr = 13'(500 + c);
            cpu_we = (c == 3); cpu_wr_addr = 13'd100; cpu_wr_data = 16'hBEEF;
            #1;
            total++; if (gpu_grant !== 1'b1) begin bad++; $display("FAIL wr_gpu_grant[%0d] got=%b exp=1", c, gpu_grant); end
            total++; if (mem_dout_we !== (c == 3)) begin bad++; $display("FAIL wr_we[%0d] got=%b exp=%b", c, mem_dout_we, (c == 3)); end
            if (c == 3) begin
                total++; if (mem_dout_addr !== 13'd100 || mem_dout !== 16'hBEEF) begin bad++; $display("FAIL wr_path got=%0d/%h exp=100/beef", mem_dout_addr, mem_dout); end
            end
        end
        @(negedge clk);
        gpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        cpu_rd_req = 1'b1; cpu_rd_addr = 13'd100;
        #1;
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL wr_readback_stall got=%b exp=0", cpu_stall); end
        @(posedge clk); #1;
        total++; if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 16'hBEEF) begin bad++; $display("FAIL wr_readback got=%b/%h exp=1/beef", cpu_rd_valid, cpu_rd_data); end
        @(negedge clk);
        cpu_rd_req = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        logic exp_g;
        apply_reset;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            gpu_req = 1'b1; gpu_addr = 13'(600 + c);
        end
        @(posedge clk); #1;
        total++; if (gpu_rd_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%b exp=1", gpu_rd_valid); end
        #1;
        reset = 1'b0;
        #1;
        total++; if (gpu_rd_valid !== 1'b0 || cpu_rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid_clear got=g%b/c%b exp=0/0", gpu_rd_valid, cpu_rd_valid); end
        cpu_rd_req = 1'b1; cpu_rd_addr = 13'd41;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            gpu_addr = 13'(700 + c);
            exp_g = (c < 8);
            #1;
            total++; if (gpu_grant !== exp_g || cpu_stall !== exp_g) begin bad++; $display("FAIL midrst_burst[%0d] got=g%b/s%b exp=%b", c, gpu_grant, cpu_stall, exp_g); end
            @(posedge clk); #1;
            total++; if (gpu_rd_valid !== exp_g) begin bad++; $display("FAIL midrst_valid[%0d] got=%b exp=%b", c, gpu_rd_valid, exp_g); end
        end
        @(negedge clk);
        cpu_rd_req = 1'b0; gpu_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = pre(i);
        test_reset;
        test_cpu_stream;
        test_contention;
        test_burst_cap;
        test_write_during_burst;
        test_reset_mid_burst;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
